// File: rtl/output_serializer.sv
// SAP-1 output port: captures the W-bus byte on OUT into a display register and a FIFO,
// then a UART-style framer drains the FIFO LSB first. Define OUTPUT_SERIALIZER_PARITY_EN for an even-parity bit.
module output_serializer #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_load,
  output logic [DATA_W-1:0] out_reg,
  output logic              fifo_full,
  output logic              overflow,
  output logic              tx_serial,
  output logic              tx_busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MAX  = CW'(DATA_W - 1);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_nx;
  logic [BW-1:0]     baud_cnt, baud_nx;
  logic [CW-1:0]     bit_cnt, bit_nx;
  logic [DATA_W-1:0] shift, shift_nx;
  logic              tx_nx;
  logic              par_q, par_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, pop, push, drop, baud_last;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = out_load && (!fifo_full || pop);
  assign drop      = out_load && fifo_full && !pop;
  assign baud_last = (baud_cnt == BAUD_MAX);
  assign tx_busy   = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    par_nx   = par_q;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) pop = 1'b1;
      START: begin
        if (baud_last) begin
          baud_nx  = '0;
          state_nx = DATA;
        end else baud_nx = baud_cnt + BW'(1);
      end
      DATA: begin
        if (baud_last) begin
          baud_nx  = '0;
          shift_nx = shift >> 1;
          if (bit_cnt == BIT_MAX) begin
            bit_nx = '0;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else bit_nx = bit_cnt + CW'(1);
        end else baud_nx = baud_cnt + BW'(1);
      end
`ifdef OUTPUT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_nx  = '0;
          state_nx = STOP;
        end else baud_nx = baud_cnt + BW'(1);
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_nx  = '0;
          state_nx = IDLE;
          if (!empty) pop = 1'b1;
        end else baud_nx = baud_cnt + BW'(1);
      end
      default: state_nx = IDLE;
    endcase
    // Loading the head restarts the frame with no idle gap.
    if (pop) begin
      shift_nx = mem[rd_ptr[AW-1:0]];
      par_nx   = ^mem[rd_ptr[AW-1:0]];
      baud_nx  = '0;
      bit_nx   = '0;
      state_nx = START;
    end
  end

  // Line level is registered from the next state so it never glitches.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:  tx_nx = 1'b0;
      DATA:   tx_nx = shift_nx[0];
`ifdef OUTPUT_SERIALIZER_PARITY_EN
      PARITY: tx_nx = par_nx;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_reg   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_nx;
      bit_cnt   <= bit_nx;
      shift     <= shift_nx;
      par_q     <= par_nx;
      tx_serial <= tx_nx;
      if (push)     wr_ptr   <= wr_ptr + (AW+1)'(1);
      if (pop)      rd_ptr   <= rd_ptr + (AW+1)'(1);
      if (out_load) out_reg  <= data_in;
      if (drop)     overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: a line monitor decodes frames and checks them
// against a scoreboard of bytes queued by the stimulus.
module tb_output_serializer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
  localparam int NSYM = DATA_W + 3;
`else
  localparam int NSYM = DATA_W + 2;
`endif
  localparam int FRAME = NSYM * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              out_load = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] out_reg;
  logic              fifo_full, overflow, tx_serial, tx_busy;

  output_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .out_load(out_load),
    .out_reg(out_reg), .fifo_full(fifo_full), .overflow(overflow),
    .tx_serial(tx_serial), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int frames = 0;
  logic [DATA_W-1:0] exp_q[$];
  int gap_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input logic [FRAME-1:0] smp);
    logic [DATA_W-1:0] e, dec;
    int bad;
    logic b;
    frames++;
    if (exp_q.size() == 0) begin
      chk("sb_frame_without_byte", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    bad = 0;
    dec = '0;
    for (int i = 0; i < FRAME; i++) begin
      int s;
      s = i / CPB;
      if (s == 0) b = 1'b0;
      else if (s <= DATA_W) b = e[s-1];
`ifdef OUTPUT_SERIALIZER_PARITY_EN
      else if (s == DATA_W + 1) b = ^e;
`endif
      else b = 1'b1;
      if (smp[i] !== b) bad++;
    end
    for (int k = 0; k < DATA_W; k++) dec[k] = smp[(k+1)*CPB + CPB/2];
    chk("frame_data", dec, e);
    chk("frame_bit_errors", bad, 0);
  endtask

  // Line monitor: samples every negedge, one sample per cycle of the frame.
  initial begin : mon
    int cnt;
    int idle;
    logic [FRAME-1:0] smp;
    cnt = 0; idle = 0; smp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; idle = 0;
      end else if (cnt == 0) begin
        if (tx_serial === 1'b0) begin
          gap_q.push_back(idle);
          idle = 0; smp = '0; cnt = 1;
        end else idle++;
      end else begin
        smp[cnt] = tx_serial;
        cnt++;
        if (cnt == FRAME) begin
          check_frame(smp);
          cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [DATA_W-1:0] d);
    @(negedge clk);
    out_load = 1'b1;
    data_in  = d;
  endtask

  task automatic release_load();
    @(negedge clk);
    out_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_within_budget", (t < budget), 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_reg", out_reg, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_tx_busy", tx_busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : stim
    int f0;
    do_reset();

    // Reset in the middle of a frame.
    drive(8'hA5); exp_q.push_back(8'hA5);
    release_load();
    repeat (10) @(negedge clk);
    chk("midframe_line_low", tx_serial, 0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midframe_rst_tx", tx_serial, 1);
    chk("midframe_rst_busy", tx_busy, 0);
    chk("midframe_rst_out_reg", out_reg, 0);
    chk("midframe_rst_full", fifo_full, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    f0 = frames;
    repeat (2*FRAME) @(negedge clk);
    chk("no_frame_after_reset", frames - f0, 0);
    chk("line_idle_after_reset", tx_serial, 1);
    chk("busy_idle_after_reset", tx_busy, 0);

    // Single byte: latency and frame length.
    f0 = frames;
    drive(8'hA5); exp_q.push_back(8'hA5);
    release_load();
    chk("single_pre_start_line", tx_serial, 1);
    chk("single_busy_after_push", tx_busy, 1);
    chk("single_out_reg", out_reg, 8'hA5);
    @(negedge clk);
    chk("single_start_fall", tx_serial, 0);
    repeat (FRAME-1) @(negedge clk);
    chk("single_busy_last_cycle", tx_busy, 1);
    chk("single_stop_line", tx_serial, 1);
    @(negedge clk);
    chk("single_busy_falls", tx_busy, 0);
    chk("single_sb_drained", exp_q.size(), 0);
    chk("single_frame_count", frames - f0, 1);

    // Back-to-back frames with no idle gap.
    gap_q.delete();
    f0 = frames;
    drive(8'h01); exp_q.push_back(8'h01);
    drive(8'h02); exp_q.push_back(8'h02);
    drive(8'h03); exp_q.push_back(8'h03);
    release_load();
    chk("b2b_out_reg", out_reg, 8'h03);
    wait_idle(4*FRAME);
    chk("b2b_frame_count", frames - f0, 3);
    chk("b2b_sb_drained", exp_q.size(), 0);
    chk("b2b_gaps_seen", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      chk("b2b_gap_1", gap_q[1], 0);
      chk("b2b_gap_2", gap_q[2], 0);
    end

    // Full FIFO accepts a push on the same edge STOP pops.
    gap_q.delete();
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      drive(8'hA0 + 8'(i)); exp_q.push_back(8'hA0 + 8'(i));
    end
    release_load();
    chk("simpop_full_after_fill", fifo_full, 1);
    repeat (FRAME-4) @(negedge clk);
    chk("simpop_full_before_pop", fifo_full, 1);
    out_load = 1'b1; data_in = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    out_load = 1'b0;
    chk("simpop_overflow_clear", overflow, 0);
    chk("simpop_still_full", fifo_full, 1);
    chk("simpop_out_reg", out_reg, 8'h77);
    wait_idle(7*FRAME);
    chk("simpop_frame_count", frames - f0, 6);
    chk("simpop_sb_drained", exp_q.size(), 0);
    chk("simpop_overflow_final", overflow, 0);
    for (int i = 1; i < gap_q.size(); i++) chk("simpop_gap", gap_q[i], 0);

    // Overflow: sixth byte dropped.
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      drive(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    chk("ovf_full_before_drop", fifo_full, 1);
    chk("ovf_not_yet", overflow, 0);
    out_load = 1'b1; data_in = 8'h15;
    release_load();
    chk("ovf_set", overflow, 1);
    chk("ovf_full_after", fifo_full, 1);
    chk("ovf_out_reg", out_reg, 8'h15);
    wait_idle(7*FRAME);
    chk("ovf_frame_count", frames - f0, 5);
    chk("ovf_sb_drained", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    // Parity bit values.
    f0 = frames;
    drive(8'h07); exp_q.push_back(8'h07);
    release_load();
    wait_idle(2*FRAME);
    drive(8'h03); exp_q.push_back(8'h03);
    release_load();
    wait_idle(2*FRAME);
    chk("par_frame_count", frames - f0, 2);
    chk("par_sb_drained", exp_q.size(), 0);
`endif

    do_reset();
    repeat (3) @(negedge clk);
    chk("final_overflow_cleared", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
